// File: rtl/dbf_line_seq.sv
// -----------------------------------------------------------------------------
// dbf_line_seq
// Scan-line sequencer for a digital receive beamformer. One line_trig runs a
// line through TX -> SETTLE -> RX -> DONE. Phases whose latched length is zero
// are skipped. During RX the focal-zone LUT address steps every zone_len
// samples and saturates at last_zone.
//
// Ports
//   clk          : single rising-edge clock
//   rst_n        : asynchronous active-low reset
//   line_trig    : one-cycle request to start a scan line (ignored while busy)
//   abort        : synchronous line cancel, wins over line_trig
//   tx_len       : transmit-window length in cycles
//   settle_len   : idle cycles between TX and RX
//   rx_len       : receive-window length in samples
//   zone_len     : samples per focal zone (0 behaves as 1)
//   last_zone    : highest valid LUT address
//   tx_en        : transmit window
//   start        : receive-beamforming enable
//   dbf_lut_addr : current focal-zone LUT address
//   dbf_lut_we   : one-cycle LUT advance strobe
//   busy         : high in every state except IDLE
//   line_done    : one-cycle end-of-line pulse
//   err_retrig   : one-cycle pulse, line_trig seen while busy
// -----------------------------------------------------------------------------
module dbf_line_seq #(
   parameter int ADDR_WD = 8,
   parameter int CNT_WD  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               line_trig,
   input  logic               abort,
   input  logic [CNT_WD-1:0]  tx_len,
   input  logic [CNT_WD-1:0]  settle_len,
   input  logic [CNT_WD-1:0]  rx_len,
   input  logic [CNT_WD-1:0]  zone_len,
   input  logic [ADDR_WD-1:0] last_zone,
   output logic               tx_en,
   output logic               start,
   output logic [ADDR_WD-1:0] dbf_lut_addr,
   output logic               dbf_lut_we,
   output logic               busy,
   output logic               line_done,
   output logic               err_retrig
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TX     = 3'd1,
      S_SETTLE = 3'd2,
      S_RX     = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [CNT_WD-1:0]  CNT_ZERO  = '0;
   localparam logic [CNT_WD-1:0]  CNT_ONE   = {{(CNT_WD-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WD-1:0] ADDR_ONE  = {{(ADDR_WD-1){1'b0}}, 1'b1};

   state_t             state_q;
   logic [CNT_WD-1:0]  cnt_q;        // cycles remaining in the current phase after this one
   logic [CNT_WD-1:0]  zcnt_q;       // 1-based index of the current sample inside its zone
   logic [CNT_WD-1:0]  settle_q;
   logic [CNT_WD-1:0]  rx_q;
   logic [CNT_WD-1:0]  zone_q;
   logic [ADDR_WD-1:0] last_q;
   logic [ADDR_WD-1:0] addr_q;
   logic               tx_en_q;
   logic               start_q;
   logic               we_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;

   // Phase-entry decision: lengths still ahead of the current state
   logic [CNT_WD-1:0]  l_tx;
   logic [CNT_WD-1:0]  l_set;
   logic [CNT_WD-1:0]  l_rx;
   state_t             ent_state;
   logic [CNT_WD-1:0]  ent_cnt;
   logic               do_enter;

   // Zone stepping
   logic [CNT_WD-1:0]  zone_eff;
   logic [CNT_WD-1:0]  zcnt_next;
   logic               adv;

   always_comb begin
      l_tx  = CNT_ZERO;
      l_set = CNT_ZERO;
      l_rx  = CNT_ZERO;
      case (state_q)
         S_IDLE: begin
            // Straight from the ports: this is the cycle they get latched
            l_tx  = tx_len;
            l_set = settle_len;
            l_rx  = rx_len;
         end
         S_TX: begin
            l_set = settle_q;
            l_rx  = rx_q;
         end
         S_SETTLE: begin
            l_rx  = rx_q;
         end
         default: ;
      endcase

      // First phase with a non-zero length wins; the counter is loaded with
      // length-1 so an all-ones length never needs a wider counter.
      ent_state = S_DONE;
      ent_cnt   = CNT_ZERO;
      if (l_tx != CNT_ZERO) begin
         ent_state = S_TX;
         ent_cnt   = l_tx - CNT_ONE;
      end else if (l_set != CNT_ZERO) begin
         ent_state = S_SETTLE;
         ent_cnt   = l_set - CNT_ONE;
      end else if (l_rx != CNT_ZERO) begin
         ent_state = S_RX;
         ent_cnt   = l_rx - CNT_ONE;
      end

      do_enter = ((state_q == S_IDLE)   && line_trig) ||
                 ((state_q == S_TX)     && (cnt_q == CNT_ZERO)) ||
                 ((state_q == S_SETTLE) && (cnt_q == CNT_ZERO));
   end

   always_comb begin
      zone_eff  = (zone_q == CNT_ZERO) ? CNT_ONE : zone_q;
      zcnt_next = (zcnt_q >= zone_eff) ? CNT_ONE : zcnt_q + CNT_ONE;
      // Advance when the next sample closes a zone. cnt_q > 1 guarantees the
      // next sample exists and is not the last one of the line.
      adv = (state_q == S_RX) && (cnt_q > CNT_ONE) &&
            (zcnt_next == zone_eff) && (addr_q != last_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         zcnt_q   <= '0;
         settle_q <= '0;
         rx_q     <= '0;
         zone_q   <= '0;
         last_q   <= '0;
         addr_q   <= '0;
         tx_en_q  <= 1'b0;
         start_q  <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (abort) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         zcnt_q   <= '0;
         addr_q   <= '0;
         tx_en_q  <= 1'b0;
         start_q  <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         we_q  <= 1'b0;
         done_q <= 1'b0;
         err_q <= line_trig && (state_q != S_IDLE);

         if ((state_q == S_IDLE) && line_trig) begin
            settle_q <= settle_len;
            rx_q     <= rx_len;
            zone_q   <= zone_len;
            last_q   <= last_zone;
         end

         if (do_enter) begin
            state_q <= ent_state;
            cnt_q   <= ent_cnt;
            zcnt_q  <= CNT_ONE;
            addr_q  <= '0;
            tx_en_q <= (ent_state == S_TX);
            start_q <= (ent_state == S_RX);
            done_q  <= (ent_state == S_DONE);
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               S_TX, S_SETTLE: begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
               S_RX: begin
                  if (cnt_q == CNT_ZERO) begin
                     state_q <= S_DONE;
                     start_q <= 1'b0;
                     done_q  <= 1'b1;
                     addr_q  <= '0;
                     zcnt_q  <= '0;
                  end else begin
                     cnt_q  <= cnt_q - CNT_ONE;
                     zcnt_q <= zcnt_next;
                     if (adv) begin
                        addr_q <= addr_q + ADDR_ONE;
                        we_q   <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign tx_en        = tx_en_q;
   assign start        = start_q;
   assign dbf_lut_addr = addr_q;
   assign dbf_lut_we   = we_q;
   assign busy         = busy_q;
   assign line_done    = done_q;
   assign err_retrig   = err_q;

endmodule

// File: tb/tb_dbf_line_seq.sv
// Directed bench for dbf_line_seq. Cycle k is the interval after the k-th
// rising edge following the line_trig cycle (cycle 0).
module tb_dbf_line_seq;

   localparam int ADDR_WD = 8;
   localparam int CNT_WD  = 8;
   localparam int MAXC    = 300;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               line_trig;
   logic               abort;
   logic [CNT_WD-1:0]  tx_len, settle_len, rx_len, zone_len;
   logic [ADDR_WD-1:0] last_zone;
   logic               tx_en, start, dbf_lut_we, busy, line_done, err_retrig;
   logic [ADDR_WD-1:0] dbf_lut_addr;

   int n_cmp = 0;
   int n_bad = 0;

   // obs bits: {tx_en, start, we, line_done, busy, err_retrig}
   logic [5:0]         obs_a  [0:MAXC];
   logic [ADDR_WD-1:0] addr_a [0:MAXC];

   always #5 clk = ~clk;

   dbf_line_seq #(.ADDR_WD(ADDR_WD), .CNT_WD(CNT_WD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .line_trig    (line_trig),
      .abort        (abort),
      .tx_len       (tx_len),
      .settle_len   (settle_len),
      .rx_len       (rx_len),
      .zone_len     (zone_len),
      .last_zone    (last_zone),
      .tx_en        (tx_en),
      .start        (start),
      .dbf_lut_addr (dbf_lut_addr),
      .dbf_lut_we   (dbf_lut_we),
      .busy         (busy),
      .line_done    (line_done),
      .err_retrig   (err_retrig)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int t, input int s, input int r, input int z, input int l);
      tx_len     = CNT_WD'(t);
      settle_len = CNT_WD'(s);
      rx_len     = CNT_WD'(r);
      zone_len   = CNT_WD'(z);
      last_zone  = ADDR_WD'(l);
   endtask

   // Trigger in cycle 0, then capture cycles 1..ncyc. Inputs are scrambled in
   // cycle 1 to show the line uses the latched copies.
   task automatic run_line(input int ncyc, input int retrig_at, input int abort_at);
      line_trig = 1'b1;
      abort     = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         cyc();
         line_trig = (k == retrig_at);
         abort     = (k == abort_at);
         if (k == 1) begin
            tx_len = 8'd1; settle_len = 8'd3; rx_len = 8'd2; zone_len = 8'd1; last_zone = 8'd0;
         end
         obs_a[k]  = {tx_en, start, dbf_lut_we, line_done, busy, err_retrig};
         addr_a[k] = dbf_lut_addr;
      end
      line_trig = 1'b0;
      abort     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; line_trig = 1'b0; abort = 1'b0;
      set_cfg(4, 2, 10, 3, 7);
      cyc(); cyc();
      n_cmp++;
      if ({tx_en, start, dbf_lut_we, line_done, busy, err_retrig} !== 6'b0 || dbf_lut_addr !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got obs=%b addr=%0d, want obs=000000 addr=0",
                  {tx_en, start, dbf_lut_we, line_done, busy, err_retrig}, dbf_lut_addr);
      end
      @(negedge clk); rst_n = 1'b1;
      cyc(); cyc();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle_busy: got %b, want 0", busy);
      end
   endtask

   task automatic test_basic();
      logic [5:0] e;
      logic [ADDR_WD-1:0] ea;
      set_cfg(4, 2, 10, 3, 7);
      run_line(20, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         e  = {k >= 1 && k <= 4, k >= 7 && k <= 16, k == 9 || k == 12 || k == 15,
               k == 17, k >= 1 && k <= 17, 1'b0};
         ea = (k >= 9 && k <= 11) ? 8'd1 : (k >= 12 && k <= 14) ? 8'd2 :
              (k >= 15 && k <= 16) ? 8'd3 : 8'd0;
         n_cmp++;
         if (obs_a[k] !== e || addr_a[k] !== ea) begin
            n_bad++;
            $display("FAIL basic cycle %0d: got obs=%b addr=%0d, want obs=%b addr=%0d",
                     k, obs_a[k], addr_a[k], e, ea);
         end
      end
      $display("basic line: 20 cycles checked");
   endtask

   task automatic test_saturation();
      int nwe;
      set_cfg(0, 0, 20, 2, 3);
      run_line(23, 0, 0);
      nwe = 0;
      for (int k = 1; k <= 23; k++) nwe += int'(obs_a[k][3]);
      n_cmp++;
      if (nwe !== 3) begin
         n_bad++;
         $display("FAIL sat_we_count: got %0d, want 3", nwe);
      end
      n_cmp++;
      if ({obs_a[2][3], obs_a[4][3], obs_a[6][3], addr_a[6]} !== {3'b111, 8'd3}) begin
         n_bad++;
         $display("FAIL sat_we_pos: got we2/4/6=%b%b%b addr6=%0d, want 111 addr 3",
                  obs_a[2][3], obs_a[4][3], obs_a[6][3], addr_a[6]);
      end
      n_cmp++;
      if (addr_a[20] !== 8'd3 || obs_a[20][4] !== 1'b1) begin
         n_bad++;
         $display("FAIL sat_hold: got addr=%0d start=%b at cycle 20, want 3 and 1", addr_a[20], obs_a[20][4]);
      end
      n_cmp++;
      if (obs_a[21][2] !== 1'b1 || addr_a[21] !== 8'd0) begin
         n_bad++;
         $display("FAIL sat_done: got done=%b addr=%0d at cycle 21, want 1 and 0", obs_a[21][2], addr_a[21]);
      end
      $display("saturation: we pulses=%0d", nwe);
   endtask

   task automatic test_skips();
      logic [5:0] e;
      set_cfg(0, 0, 5, 3, 7);
      run_line(8, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         e = {1'b0, k <= 5, k == 3, k == 6, k <= 6, 1'b0};
         n_cmp++;
         if (obs_a[k] !== e) begin
            n_bad++;
            $display("FAIL skip_rx cycle %0d: got obs=%b, want %b", k, obs_a[k], e);
         end
      end
      set_cfg(0, 0, 0, 3, 7);
      run_line(3, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         e = {3'b000, k == 1, k == 1, 1'b0};
         n_cmp++;
         if (obs_a[k] !== e) begin
            n_bad++;
            $display("FAIL skip_all cycle %0d: got obs=%b, want %b", k, obs_a[k], e);
         end
      end
      $display("skips: rx-only and empty lines checked");
   endtask

   task automatic test_final_sample();
      int nwe;
      set_cfg(0, 0, 6, 3, 7);
      run_line(8, 0, 0);
      nwe = 0;
      for (int k = 1; k <= 8; k++) nwe += int'(obs_a[k][3]);
      n_cmp++;
      if (nwe !== 1 || obs_a[6][3] !== 1'b0 || addr_a[6] !== 8'd1) begin
         n_bad++;
         $display("FAIL final_sample: got we=%0d we6=%b addr6=%0d, want 1 0 1", nwe, obs_a[6][3], addr_a[6]);
      end
      $display("final sample: we pulses=%0d", nwe);
   endtask

   task automatic test_retrig();
      logic [5:0] e;
      set_cfg(4, 2, 10, 3, 7);
      run_line(20, 10, 0);
      for (int k = 1; k <= 20; k++) begin
         e = {k >= 1 && k <= 4, k >= 7 && k <= 16, k == 9 || k == 12 || k == 15,
              k == 17, k >= 1 && k <= 17, k == 11};
         n_cmp++;
         if (obs_a[k] !== e) begin
            n_bad++;
            $display("FAIL retrig cycle %0d: got obs=%b, want %b", k, obs_a[k], e);
         end
      end
      // Trigger in the DONE cycle is flagged and ignored
      set_cfg(4, 2, 10, 3, 7);
      run_line(20, 17, 0);
      n_cmp++;
      if (obs_a[18] !== 6'b000001 || obs_a[19] !== 6'b000000 || obs_a[20] !== 6'b000000) begin
         n_bad++;
         $display("FAIL retrig_done: got c18=%b c19=%b c20=%b, want 000001 000000 000000",
                  obs_a[18], obs_a[19], obs_a[20]);
      end
      $display("retrigger: RX and DONE cases checked");
   endtask

   task automatic test_abort();
      logic [5:0] bad;
      set_cfg(4, 2, 10, 3, 7);
      run_line(20, 2, 2);
      bad = '0;
      for (int k = 3; k <= 20; k++) bad = bad | obs_a[k];
      n_cmp++;
      if (obs_a[2][5] !== 1'b1 || bad !== 6'b0 || addr_a[3] !== 8'd0) begin
         n_bad++;
         $display("FAIL abort: got tx2=%b or_after=%b addr3=%0d, want 1 000000 0", obs_a[2][5], bad, addr_a[3]);
      end
      set_cfg(4, 2, 10, 3, 7);
      run_line(20, 0, 0);
      n_cmp++;
      if (obs_a[1] !== 6'b100010 || obs_a[7] !== 6'b010010 || obs_a[17] !== 6'b000110) begin
         n_bad++;
         $display("FAIL abort_relaunch: got c1=%b c7=%b c17=%b, want 100010 010010 000110",
                  obs_a[1], obs_a[7], obs_a[17]);
      end
      $display("abort: cancel and relaunch checked");
   endtask

   task automatic test_reset_mid();
      set_cfg(4, 2, 10, 3, 7);
      run_line(10, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs_a[10] !== 6'b010010 || addr_a[10] !== 8'd1) begin
         n_bad++;
         $display("FAIL reset_mid_pre: got obs=%b addr=%0d, want 010010 1", obs_a[10], addr_a[10]);
      end
      n_cmp++;
      if ({tx_en, start, dbf_lut_we, line_done, busy, err_retrig} !== 6'b0 || dbf_lut_addr !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_async: got obs=%b addr=%0d, want 000000 0",
                  {tx_en, start, dbf_lut_we, line_done, busy, err_retrig}, dbf_lut_addr);
      end
      @(negedge clk); rst_n = 1'b1;
      cyc();
      set_cfg(4, 2, 10, 3, 7);
      run_line(18, 0, 0);
      n_cmp++;
      if (obs_a[1] !== 6'b100010 || obs_a[9] !== 6'b011010 || obs_a[17] !== 6'b000110 || obs_a[18] !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_mid_fresh: got c1=%b c9=%b c17=%b c18=%b", obs_a[1], obs_a[9], obs_a[17], obs_a[18]);
      end
      $display("reset mid-line: async clear and fresh line checked");
   endtask

   task automatic test_all_ones();
      int ntx;
      set_cfg(255, 0, 1, 0, 7);
      run_line(259, 0, 0);
      ntx = 0;
      for (int k = 1; k <= 259; k++) ntx += int'(obs_a[k][5]);
      n_cmp++;
      if (ntx !== 255 || obs_a[255][5] !== 1'b1 || obs_a[256] !== 6'b010010 || obs_a[257] !== 6'b000110) begin
         n_bad++;
         $display("FAIL all_ones: got tx_cycles=%0d c256=%b c257=%b, want 255 010010 000110",
                  ntx, obs_a[256], obs_a[257]);
      end
      $display("all-ones length: tx cycles=%0d", ntx);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_skips();
      test_final_sample();
      test_retrig();
      test_abort();
      test_reset_mid();
      test_all_ones();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dbf_line_seq.md
DBF_LINE_SEQ -- requirements
Module: dbf_line_seq

Interface
REQ-001 Parameter ADDR_WD, default 8, width of the delay/apodisation LUT address.
REQ-002 Parameter CNT_WD, default 16, width of all length counters.
REQ-003 Port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port line_trig, input, 1, one-cycle request to start a scan line.
REQ-006 Port abort, input, 1, synchronous line cancel.
REQ-007 Port tx_len, input, CNT_WD, transmit-window length in cycles.
REQ-008 Port settle_len, input, CNT_WD, idle cycles between TX and RX.
REQ-009 Port rx_len, input, CNT_WD, receive-window length in samples.
REQ-010 Port zone_len, input, CNT_WD, samples per focal zone.
REQ-011 Port last_zone, input, ADDR_WD, highest valid LUT address.
REQ-012 Port tx_en, output, 1, transmit window; channel input is invalid while high.
REQ-013 Port start, output, 1, receive-beamforming enable to all channels.
REQ-014 Port dbf_lut_addr, output, ADDR_WD, current focal-zone LUT address.
REQ-015 Port dbf_lut_we, output, 1, one-cycle LUT advance strobe.
REQ-016 Port busy, output, 1, high in any state other than IDLE.
REQ-017 Port line_done, output, 1, one-cycle end-of-line pulse.
REQ-018 Port err_retrig, output, 1, one-cycle pulse when line_trig arrives while busy.

Function
REQ-019 The block SHALL use states IDLE, TX, SETTLE, RX and DONE, with all outputs registered.
REQ-020 In IDLE, line_trig SHALL latch tx_len, settle_len, rx_len, zone_len and last_zone; a later change on these inputs SHALL not affect the active line.
REQ-021 After line_trig in cycle 0, the next state SHALL be the first state whose latched length is non-zero, in the order TX, SETTLE, RX, else DONE; it is entered in cycle 1.
REQ-022 In TX, tx_en SHALL be 1 for exactly tx_len cycles, then the block exits by the same skip rule.
REQ-023 In SETTLE, tx_en and start SHALL both be 0 for exactly settle_len cycles.
REQ-024 In RX, start SHALL be 1 for exactly rx_len cycles, then the state SHALL be DONE.
REQ-025 On entry to RX, dbf_lut_addr SHALL be 0.
REQ-026 A zone counter SHALL count RX samples; every zone_len samples (zone_len=0 treated as 1), dbf_lut_addr SHALL increment in the same cycle as a one-cycle dbf_lut_we pulse.
REQ-027 dbf_lut_addr SHALL saturate at last_zone; no further dbf_lut_we pulses SHALL be issued once it is there.
REQ-028 No advance SHALL occur on the final RX sample.
REQ-029 In DONE, line_done SHALL be 1 for one cycle, dbf_lut_addr SHALL clear to 0, and the state SHALL return to IDLE.
REQ-030 line_trig while busy SHALL be ignored, and err_retrig SHALL pulse 1 the next cycle.
REQ-031 line_trig in the DONE cycle SHALL be ignored as busy.
REQ-032 abort SHALL force IDLE on the next edge, with all outputs 0 and no line_done; abort has priority over line_trig in the same cycle.
REQ-033 Counters SHALL never wrap: a length of all-ones yields exactly 2^CNT_WD-1 cycles.
REQ-034 tx_en and start SHALL never be 1 simultaneously.

Reset
REQ-035 While rst_n=0, the state SHALL be IDLE, all counters 0, and tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done and err_retrig all 0.
REQ-036 Reset assertion mid-line SHALL abandon the line immediately; the first line_trig after release SHALL start a fresh line.

Verification
REQ-037 Basic line: tx=4, settle=2, rx=10, zone=3, last_zone=7, trig at cycle 0 -> tx_en in cycles 1-4, gap in cycles 5-6, start in cycles 7-16, dbf_lut_we at the 3rd/6th/9th samples with addr 1/2/3, line_done in cycle 17.
REQ-038 Saturation: rx=20, zone=2, last_zone=3 -> addr stops at 3 and exactly 3 dbf_lut_we pulses.
REQ-039 Skips: tx=0, settle=0, rx=5 -> start in cycles 1-5 and no tx_en; all lengths 0 -> line_done in cycle 1.
REQ-040 Retrigger: line_trig during RX -> err_retrig single pulse, line timing unchanged.
REQ-041 Abort plus trig in the same cycle during TX -> IDLE, no line_done; a new trig then gives a normal line.
REQ-042 Async reset during RX -> all outputs 0 without a clock edge.
